uart_tx_arbiter: RTL

Shares one UART transmit line between two byte requesters (switch-entry path and message path) and sequences the serial frame itself.
- Owns baud timing, frame state machine and round-robin arbitration.
- Sits between request sources and the GPIO tx pin; replaces ad-hoc button-triggered load/enable sequencing of the shift path.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the two-requester UART transmitter.
// UART_ARB_PARITY_EN adds an even-parity bit (11-bit frame).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int unsigned DEF_CLKS_PER_BIT = 5208;
  localparam int unsigned DATA_BITS        = 8;

`ifdef UART_ARB_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_bit_done_c
);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_done_c = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Wrap on bit end so every state/bit change starts from zero.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || o_bit_done_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter for two byte requesters driving one UART tx line.
// Optional macro: UART_ARB_PARITY_EN (even parity bit after the data bits).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] grant,
  output logic       busy,
  output logic       cur_src,
  output logic       tx
);

  state_e      r_state;
  logic [7:0]  r_data;
  logic [2:0]  r_bit_idx;
  logic        r_rr;
  logic [1:0]  r_grant;
  logic        r_busy;
  logic        r_src;
  logic        r_tx;
  logic        w_bit_done;
  logic        w_win;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .i_clk        (CLOCK_50),
    .i_reset      (reset),
    .i_clear      (r_state == IDLE),
    .o_bit_done_c (w_bit_done)
  );

  // r_rr holds the preferred requester when both ask at once.
  always_comb begin
    w_win = 1'b0;
    if (req == 2'b11) begin
      w_win = r_rr;
    end else begin
      w_win = req[1];
    end
  end

  // tx and busy are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_bit_idx <= '0;
      r_rr      <= 1'b0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_src     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_grant <= '0;
      r_busy  <= (r_state != IDLE);
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (req != 2'b00) begin
            r_grant   <= w_win ? 2'b10 : 2'b01;
            r_src     <= w_win;
            r_data    <= w_win ? data1 : data0;
            r_rr      <= ~w_win;
            r_bit_idx <= '0;
            r_state   <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (w_bit_done) begin
            r_bit_idx <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          r_tx <= r_data[r_bit_idx];
          if (w_bit_done) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_ARB_PARITY_EN
        PARITY: begin
          r_tx <= ^r_data;
          if (w_bit_done) begin
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          r_tx <= 1'b1;
          if (w_bit_done) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign busy    = r_busy;
  assign cur_src = r_src;
  assign tx      = r_tx;

endmodule
